pixel_line_doubler: RTL and testbench
=====================================

// Module: pixel_line_doubler
// PURPOSE
//  Downstream consumer of the GPU read FIFO filled by the SRAM arbiter. Pops one 8-bit pixel per
//  source pixel in raster order and emits a registered pixel stream aligned to the 50MHz-synced
//  h/v counters. In half-res mode, 320x240 is scaled 2x2 to 640x480 through an internal line buffer.
//  Otherwise the source is shown 1:1 in the top-left window with a border colour elsewhere.
//  Also drains stale FIFO entries during vsync so every frame starts aligned.
// PARAMETERS
//  H_START      144   h_count of first active display column
//  V_START      35    v_count of first active display row
//  ACT_W        640   active display width (pixels)
//  ACT_H        480   active display height (lines)
//  SRC_W        320   source frame width; line buffer depth
//  SRC_H        240   source frame height
//  BORDER_COL   8'h00 colour outside the source window / active area
//  UFLOW_COL    8'hE0 colour substituted on FIFO underflow
// PORTS
//  clk          in   1   50MHz system clock
//  reset        in   1   synchronous, active-high
//  pixel_en     in   1   one-cycle strobe per display pixel (every 2nd clk); h/v valid this cycle
//  h_count      in   12  horizontal position (clk-synced)
//  v_count      in   12  vertical position (clk-synced)
//  vsync        in   1   vertical sync (high = sync pulse)
//  half_res     in   1   1 = 2x2 scale, 0 = 1:1 window; sampled at vsync rising edge only
//  fifo_rd_data in   8   GPU FIFO data, valid the cycle after fifo_rd_en
//  fifo_empty   in   1   GPU FIFO empty
//  fifo_rd_en   out  1   GPU FIFO pop strobe
//  pixel_out    out  8   output colour
//  pixel_valid  out  1   pulses 2 clks after the pixel_en it belongs to
//  underflow    out  1   sticky: a pop was needed while fifo_empty
//  clr_uflow    in   1   clears underflow (reset wins; set wins over clear in the same cycle)
// BEHAVIOUR
//  Reset: fifo_rd_en=0, pixel_out=BORDER_COL, pixel_valid=0, underflow=0, mode reg=0,
//   pipeline cleared. Reset mid-line discards in-flight pixels; no pop is issued during reset.
//  Coordinates: hx=h_count-H_START, vy=v_count-V_START (12-bit unsigned; wrap puts out-of-range
//   values far out). active = hx<ACT_W && vy<ACT_H.
//  Mapping: half: sx=hx>>1, sy=vy>>1, in_src=active. full: sx=hx, sy=vy,
//   in_src = hx<SRC_W && vy<SRC_H.
//  Row type: fetch row = in_src && (full mode || vy[0]==0); repeat row = half mode && vy[0]==1.
//  Stage 0 (pixel_en cycle):
//   - fetch row, and (full || hx[0]==0): if !fifo_empty, assert fifo_rd_en for 1 cycle;
//     else set underflow and mark the slot as underflow.
//   - repeat row: issue line buffer read at sx.
//  Stage 1: capture fifo_rd_data, or UFLOW_COL for an underflow slot. On a fetch row, write it
//   to line_buf[sx]. Half mode, odd hx: reuse the held pixel with no pop.
//  Stage 2: pixel_out <= source pixel (fetch/repeat) or BORDER_COL (!in_src); pixel_valid=1.
//  Output latency: 2 clks after pixel_en, fixed. pixel_valid=0 on every other cycle.
//  Pop count: exactly SRC_W*SRC_H pops per frame in both modes when no underflow occurs.
//  Underflow does not pop; the stream stays shifted until the next drain.
//  Drain: while vsync==1 and !fifo_empty, assert fifo_rd_en every cycle and discard the data.
//   The arbiter restarts at vsync falling edge, so draining never eats new-frame data.
//  Mode latch: half_res is registered on the vsync rising edge. A mid-frame change has no
//   effect until the next frame.
//  pixel_en with !active: output BORDER_COL, no pop, no buffer access.
//  Assumes pixel_en never occurs while vsync==1 inside the active area (timing generator guarantee).
// STRUCTURE
//  Shared package gpu_timing_pkg: H_START, V_START, ACT_W, ACT_H, SRC_W, SRC_H, and colour
//   constants BORDER_COL, UFLOW_COL (shared with the SRAM arbiter's FRAME_PIXELS).
//  Sub-module pixel_line_buffer: SRC_W x 8 simple dual-port RAM, 1-clk synchronous read,
//   write-first is not required (the same address is never read and written in one cycle).
//  Top level: coordinate/row decode, 3-stage pixel pipeline, drain logic, sticky flag.
// TESTING
//  1 half_res=1, FIFO model preloaded with p=(x+y*320)&0xFF, full frame:
//    -> rows 0/1 identical; each pixel appears 2x; 76800 pops; underflow=0.
//  2 half_res=0, same data:
//    -> 1:1 in 320x240 window; BORDER_COL at hx=320..639 and vy>=240; 76800 pops.
//  3 fifo_empty forced for 3 pops at (sx=10,sy=5), half mode:
//    -> UFLOW_COL at hx 20..25 on vy 10 and 11; underflow=1 until clr_uflow.
//  4 leave 37 entries in FIFO at end of active, then assert vsync:
//    -> 37 consecutive pops; FIFO empty before vsync falls; next frame pixel(0,0) correct.
//  5 toggle half_res at vy=100:
//    -> current frame unchanged; new mode from the next vsync rising edge.
//  6 reset pulsed mid-line at hx=300:
//    -> next cycle: outputs at reset values, no fifo_rd_en; normal output from the next pixel_en.

Source files
------------

// File: rtl/gpu_timing_pkg.sv
// Shared display-timing and colour constants for the GPU read path.
// Also holds the pipeline slot types used by the pixel line doubler.
package gpu_timing_pkg;

    localparam int H_START      = 144;
    localparam int V_START      = 35;
    localparam int ACT_W        = 640;
    localparam int ACT_H        = 480;
    localparam int SRC_W        = 320;
    localparam int SRC_H        = 240;
    localparam int FRAME_PIXELS = SRC_W * SRC_H;
    localparam int LB_AW        = $clog2(SRC_W);

    localparam logic [7:0] BORDER_COL = 8'h00;
    localparam logic [7:0] UFLOW_COL  = 8'hE0;

    // What the middle pipeline stage must do with the slot it holds.
    typedef enum logic [2:0] {
        SLOT_BORDER,
        SLOT_POP,
        SLOT_UFLOW,
        SLOT_HOLD,
        SLOT_REPEAT
    } slotKind_e;

    typedef struct packed {
        logic             valid;
        slotKind_e        kind;
        logic [LB_AW-1:0] addr;
    } pixSlot_t;

endpackage

// File: rtl/pixel_line_buffer.sv
// One source line of pixels: simple dual-port RAM with a registered read.
// The same address is never read and written in one cycle, so no bypass.
module pixel_line_buffer
    import gpu_timing_pkg::*;
#(
    parameter int DEPTH = SRC_W,
    parameter int AW    = LB_AW,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          wrEn_i,
    input  logic [AW-1:0] wrAddr_i,
    input  logic [DW-1:0] wrData_i,
    input  logic          rdEn_i,
    input  logic [AW-1:0] rdAddr_i,
    output logic [DW-1:0] rdData_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdData_q;

    // Write port and one-cycle synchronous read port.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/pixel_line_doubler.sv
// Pops source pixels from the GPU read FIFO and emits a registered pixel
// stream, either 2x2 scaled (half-res) or 1:1 in the top-left window.
// Also drains leftover FIFO entries during vsync.
module pixel_line_doubler
    import gpu_timing_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_en,
    input  logic [11:0] h_count,
    input  logic [11:0] v_count,
    input  logic        vsync,
    input  logic        half_res,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  pixel_out,
    output logic        pixel_valid,
    output logic        underflow,
    input  logic        clr_uflow
);

    logic [11:0]      hx;
    logic [11:0]      vy;
    logic             active;
    logic             inSrc;
    logic             fetchRow;
    logic             repeatRow;
    logic             popNeeded;
    logic             uflowSet;
    logic [LB_AW-1:0] sxAddr;

    logic             halfMode_q;
    logic             vsyncPrev_q;
    pixSlot_t         slot_d;
    pixSlot_t         slot_q;
    logic [7:0]       srcPix;
    logic [7:0]       heldPix_q;
    logic [7:0]       pixOut_q;
    logic             pixValid_q;
    logic             underflow_d;
    logic             underflow_q;

    logic             lbWrEn;
    logic             lbRdEn;
    logic [7:0]       lbRdData;

    // Out-of-range counts wrap to large unsigned values and fail the window tests.
    assign hx = h_count - 12'(H_START);
    assign vy = v_count - 12'(V_START);

    // Decode window membership, source column and row type for the current position.
    always_comb begin
        active = (hx < 12'(ACT_W)) && (vy < 12'(ACT_H));
        if (halfMode_q) begin
            inSrc  = active;
            sxAddr = hx[LB_AW:1];
        end else begin
            inSrc  = (hx < 12'(SRC_W)) && (vy < 12'(SRC_H));
            sxAddr = hx[LB_AW-1:0];
        end
        fetchRow  = inSrc && (!halfMode_q || !vy[0]);
        repeatRow = inSrc && halfMode_q && vy[0];
        popNeeded = pixel_en && fetchRow && (!halfMode_q || !hx[0]);
    end

    // A needed pop on an empty FIFO is skipped and flagged instead.
    assign uflowSet   = !reset && popNeeded && fifo_empty;
    assign fifo_rd_en = !reset && !fifo_empty && (popNeeded || vsync);

    assign lbRdEn = !reset && pixel_en && repeatRow;
    assign lbWrEn = !reset && slot_q.valid &&
                    ((slot_q.kind == SLOT_POP) || (slot_q.kind == SLOT_UFLOW));

    // Classify the slot entering the pipeline on each pixel strobe.
    always_comb begin
        slot_d.valid = pixel_en;
        slot_d.addr  = sxAddr;
        slot_d.kind  = SLOT_BORDER;
        if (popNeeded) begin
            slot_d.kind = fifo_empty ? SLOT_UFLOW : SLOT_POP;
        end else if (pixel_en && fetchRow) begin
            slot_d.kind = SLOT_HOLD;
        end else if (pixel_en && repeatRow) begin
            slot_d.kind = SLOT_REPEAT;
        end
    end

    // Pick the source pixel for the slot now in the middle stage.
    always_comb begin
        srcPix = BORDER_COL;
        case (slot_q.kind)
            SLOT_POP:    srcPix = fifo_rd_data;
            SLOT_UFLOW:  srcPix = UFLOW_COL;
            SLOT_HOLD:   srcPix = heldPix_q;
            SLOT_REPEAT: srcPix = lbRdData;
            default:     srcPix = BORDER_COL;
        endcase
    end

    // Set has priority over clear; reset is applied in the register.
    always_comb begin
        underflow_d = underflow_q;
        if (uflowSet) begin
            underflow_d = 1'b1;
        end else if (clr_uflow) begin
            underflow_d = 1'b0;
        end
    end

    // Pixel pipeline: slot register, held pixel for horizontal doubling, output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q     <= '0;
            heldPix_q  <= BORDER_COL;
            pixOut_q   <= BORDER_COL;
            pixValid_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            pixValid_q <= slot_q.valid;
            if (slot_q.valid) begin
                pixOut_q <= srcPix;
            end
            if (lbWrEn) begin
                heldPix_q <= srcPix;
            end
        end
    end

    // Mode is only taken on a vsync rising edge so a frame never changes mode midway.
    always_ff @(posedge clk) begin
        if (reset) begin
            halfMode_q  <= 1'b0;
            vsyncPrev_q <= 1'b0;
        end else begin
            vsyncPrev_q <= vsync;
            if (vsync && !vsyncPrev_q) begin
                halfMode_q <= half_res;
            end
        end
    end

    // Sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    pixel_line_buffer #(
        .DEPTH (SRC_W),
        .AW    (LB_AW),
        .DW    (8)
    ) u_lineBuf (
        .clk      (clk),
        .wrEn_i   (lbWrEn),
        .wrAddr_i (slot_q.addr),
        .wrData_i (srcPix),
        .rdEn_i   (lbRdEn),
        .rdAddr_i (sxAddr),
        .rdData_o (lbRdData)
    );

    assign pixel_out   = pixOut_q;
    assign pixel_valid = pixValid_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_pixel_line_doubler.sv
// Bench for pixel_line_doubler: FIFO model, scoreboard of expected pixels,
// a coordinate decode table and hand-written multi-cycle sequences.
module tb_pixel_line_doubler;
    import gpu_timing_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_en = 1'b0;
    logic [11:0] h_count = '0;
    logic [11:0] v_count = '0;
    logic        vsync = 1'b0;
    logic        half_res = 1'b0;
    logic [7:0]  fifo_rd_data = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic        underflow;
    logic        clr_uflow = 1'b0;

    int numCompared = 0;
    int numMismatched = 0;
    int cycleCnt = 0;

    typedef struct {
        logic [7:0] pix;
        int         due;
        int         hx;
        int         vy;
    } expItem_t;

    expItem_t expQ[$];

    logic [7:0] fifoQ[$];
    int         fifoLevel = 0;
    bit         forceEmpty = 1'b0;
    int         popCount = 0;

    typedef struct {
        int         h;
        int         v;
        bit         pop;
        logic [7:0] data;
        logic [7:0] expPix;
    } vec_t;

    vec_t vecs[10];

    pixel_line_doubler dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_en     (pixel_en),
        .h_count      (h_count),
        .v_count      (v_count),
        .vsync        (vsync),
        .half_res     (half_res),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .pixel_out    (pixel_out),
        .pixel_valid  (pixel_valid),
        .underflow    (underflow),
        .clr_uflow    (clr_uflow)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency bookkeeping.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // FIFO model: data valid the cycle after a pop, level visible from the next edge.
    assign fifo_empty = forceEmpty || (fifoLevel == 0);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fifoQ.pop_front();
            popCount     <= popCount + 1;
        end
        fifoLevel <= fifoQ.size();
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        numCompared++;
        if (actual != required) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, required, required);
        end
    endtask

    // Scoreboard: compare every valid pixel against the oldest expectation and its due cycle.
    always @(negedge clk) begin
        expItem_t e;
        if (pixel_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected pixel_valid", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("pixel hx=%0d vy=%0d", e.hx, e.vy), int'(pixel_out), int'(e.pix));
                checkOutput($sformatf("latency hx=%0d vy=%0d", e.hx, e.vy), cycleCnt, e.due);
            end
        end else if (expQ.size() != 0 && expQ[0].due <= cycleCnt) begin
            e = expQ.pop_front();
            checkOutput($sformatf("missing pixel_valid hx=%0d vy=%0d", e.hx, e.vy), 0, 1);
        end
        if (fifo_rd_en === 1'b1) begin
            checkOutput("pop while empty", int'(fifo_empty), 0);
        end
    end

    // Hard stop in case something stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [7:0] img(input int x, input int y);
        return 8'((x + y * SRC_W) & 255);
    endfunction

    // Reference picture: what the display should show at (hx, vy) for a mode,
    // given ufN skipped pops starting at source column ufSx.
    function automatic logic [7:0] expPix(input bit half, input int hx, input int vy,
                                          input int ufSx, input int ufN);
        bit active;
        bit inSrc;
        int sx;
        int sy;
        active = (hx >= 0) && (hx < ACT_W) && (vy >= 0) && (vy < ACT_H);
        if (half) begin
            inSrc = active;
            sx = hx / 2;
            sy = vy / 2;
        end else begin
            inSrc = (hx >= 0) && (hx < SRC_W) && (vy >= 0) && (vy < SRC_H);
            sx = hx;
            sy = vy;
        end
        if (!inSrc) return BORDER_COL;
        if (ufN > 0 && sx >= ufSx && sx < ufSx + ufN) return UFLOW_COL;
        if (ufN > 0 && sx >= ufSx + ufN) return img(sx - ufN, sy);
        return img(sx, sy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preloadRow(input int sy);
        for (int x = 0; x < SRC_W; x++) fifoQ.push_back(img(x, sy));
        tick();
    endtask

    // One pixel strobe followed by the idle clock, with its expectation queued.
    task automatic applyStimulus(input int h, input int v, input logic [7:0] pix);
        pixel_en = 1'b1;
        h_count  = 12'(h);
        v_count  = 12'(v);
        expQ.push_back('{pix, cycleCnt + 2, h - H_START, v - V_START});
        tick();
        pixel_en = 1'b0;
        tick();
    endtask

    task automatic scanRow(input int vy, input bit half, input int ufSx, input int ufN,
                           input int expPops);
        int startPops;
        startPops = popCount;
        for (int h = H_START - 2; h <= H_START + ACT_W + 1; h++) begin
            int hx;
            int sx;
            hx = h - H_START;
            sx = half ? hx / 2 : hx;
            forceEmpty = (ufN > 0) && (hx >= 0) && (hx < ACT_W) && (sx >= ufSx) && (sx < ufSx + ufN);
            applyStimulus(h, vy + V_START, expPix(half, hx, vy, ufSx, ufN));
        end
        forceEmpty = 1'b0;
        repeat (3) tick();
        checkOutput($sformatf("pops on row vy=%0d", vy), popCount - startPops, expPops);
    endtask

    task automatic vsyncPulse(input bit half);
        half_res = half;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic drainCheck(input int expPops);
        int total;
        int run;
        bit gap;
        int startPops;
        total = 0;
        run = 0;
        gap = 1'b0;
        startPops = popCount;
        half_res = 1'b1;
        vsync = 1'b1;
        for (int i = 0; i < expPops + 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) begin
                total++;
                if (!gap) run++;
            end else if (total > 0) begin
                gap = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("drain pop strobes", total, expPops);
        checkOutput("drain consecutive run", run, expPops);
        checkOutput("drain pops taken", popCount - startPops, expPops);
        checkOutput("fifo level before vsync falls", fifoLevel, 0);
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        int startPops;

        // Decode table in 1:1 mode: window edges, wrap-around and out-of-area points.
        vecs[0] = '{H_START + 0,   V_START + 0,   1'b1, 8'h5A, 8'h5A};
        vecs[1] = '{H_START - 1,   V_START + 0,   1'b0, 8'h00, BORDER_COL};
        vecs[2] = '{H_START + 319, V_START + 239, 1'b1, 8'hC3, 8'hC3};
        vecs[3] = '{H_START + 320, V_START + 0,   1'b0, 8'h00, BORDER_COL};
        vecs[4] = '{H_START + 639, V_START + 0,   1'b0, 8'h00, BORDER_COL};
        vecs[5] = '{H_START + 640, V_START + 0,   1'b0, 8'h00, BORDER_COL};
        vecs[6] = '{H_START + 5,   V_START + 240, 1'b0, 8'h00, BORDER_COL};
        vecs[7] = '{H_START + 5,   V_START - 1,   1'b0, 8'h00, BORDER_COL};
        vecs[8] = '{H_START + 100, V_START + 100, 1'b1, 8'h81, 8'h81};
        vecs[9] = '{H_START + 5,   V_START + 480, 1'b0, 8'h00, BORDER_COL};

        // Reset values.
        repeat (3) tick();
        checkOutput("reset pixel_out", int'(pixel_out), int'(BORDER_COL));
        checkOutput("reset pixel_valid", int'(pixel_valid), 0);
        checkOutput("reset underflow", int'(underflow), 0);
        checkOutput("reset fifo_rd_en", int'(fifo_rd_en), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].pop) begin
                fifoQ.push_back(vecs[i].data);
                tick();
            end
            startPops = popCount;
            applyStimulus(vecs[i].h, vecs[i].v, vecs[i].expPix);
            tick();
            checkOutput($sformatf("table %0d pops", i), popCount - startPops, vecs[i].pop ? 1 : 0);
        end

        // Half-res: each source row shown twice, each pixel twice.
        vsyncPulse(1'b1);
        preloadRow(0);
        scanRow(0, 1'b1, 0, 0, SRC_W);
        scanRow(1, 1'b1, 0, 0, 0);
        preloadRow(1);
        scanRow(2, 1'b1, 0, 0, SRC_W);
        scanRow(3, 1'b1, 0, 0, 0);
        preloadRow(239);
        scanRow(478, 1'b1, 0, 0, SRC_W);
        scanRow(479, 1'b1, 0, 0, 0);
        checkOutput("no underflow in half-res rows", int'(underflow), 0);

        // Mode request changes mid-frame: this frame stays half-res.
        half_res = 1'b0;
        preloadRow(50);
        scanRow(100, 1'b1, 0, 0, SRC_W);
        vsyncPulse(1'b0);

        // 1:1 window with border to the right and below.
        preloadRow(0);
        scanRow(0, 1'b0, 0, 0, SRC_W);
        preloadRow(1);
        scanRow(1, 1'b0, 0, 0, SRC_W);
        preloadRow(239);
        scanRow(239, 1'b0, 0, 0, SRC_W);
        scanRow(240, 1'b0, 0, 0, 0);
        checkOutput("no underflow in 1:1 rows", int'(underflow), 0);

        // Three skipped pops at sx=10..12 on source row 5, half-res.
        vsyncPulse(1'b1);
        preloadRow(5);
        scanRow(10, 1'b1, 10, 3, SRC_W - 3);
        checkOutput("underflow set", int'(underflow), 1);
        scanRow(11, 1'b1, 10, 3, 0);
        checkOutput("underflow sticky", int'(underflow), 1);
        clr_uflow = 1'b1;
        tick();
        clr_uflow = 1'b0;
        tick();
        checkOutput("underflow cleared", int'(underflow), 0);

        // Set and clear in the same cycle: set wins.
        forceEmpty = 1'b1;
        clr_uflow  = 1'b1;
        pixel_en   = 1'b1;
        h_count    = 12'(H_START);
        v_count    = 12'(V_START + 20);
        expQ.push_back('{UFLOW_COL, cycleCnt + 2, 0, 20});
        tick();
        pixel_en   = 1'b0;
        clr_uflow  = 1'b0;
        forceEmpty = 1'b0;
        tick();
        tick();
        checkOutput("underflow set beats clear", int'(underflow), 1);

        // Drain: 3 leftovers from the skipped pops plus 34 more.
        for (int i = 0; i < 34; i++) fifoQ.push_back(8'(8'hA0 + i));
        tick();
        tick();
        drainCheck(37);
        checkOutput("underflow survives drain", int'(underflow), 1);
        preloadRow(0);
        scanRow(0, 1'b1, 0, 0, SRC_W);

        // Reset in the middle of a half-res line at hx=300.
        preloadRow(0);
        for (int hx = 0; hx < 300; hx++) applyStimulus(H_START + hx, V_START, expPix(1'b1, hx, 0, 0, 0));
        startPops = popCount;
        pixel_en = 1'b1;
        h_count  = 12'(H_START + 300);
        reset    = 1'b1;
        @(negedge clk);
        checkOutput("no pop during reset", int'(fifo_rd_en), 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        pixel_en = 1'b0;
        @(negedge clk);
        checkOutput("post-reset pixel_valid", int'(pixel_valid), 0);
        checkOutput("post-reset pixel_out", int'(pixel_out), int'(BORDER_COL));
        checkOutput("post-reset underflow", int'(underflow), 0);
        checkOutput("post-reset fifo_rd_en", int'(fifo_rd_en), 0);
        @(posedge clk);
        #1;
        checkOutput("pops through reset", popCount - startPops, 0);

        // Mode register is back to 1:1, so the stream resumes at source column 150.
        for (int hx = 302; hx < 340; hx++) begin
            applyStimulus(H_START + hx, V_START, (hx < SRC_W) ? img(150 + hx - 302, 0) : BORDER_COL);
        end
        applyStimulus(H_START + 400, V_START, BORDER_COL);
        repeat (3) tick();
        checkOutput("pops after reset", popCount - startPops, 18);

        repeat (4) tick();
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
